// File: rtl/extern_bus_arbiter_pkg.sv
// Shared types and helpers for the external peripheral bus arbiter.
package extern_bus_arbiter_pkg;

  // Host transaction FSM: idle, waiting for a free bus slot, acknowledging.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Width needed to hold a count from 0 up to and including limit.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/extern_bus_arbiter_sat_counter.sv
// Saturating up-counter that measures how long a host request has been blocked.
// hit_limit flags the edge on which the count will reach LIMIT.
module sat_counter
  import extern_bus_arbiter_pkg::*;
#(
  parameter int LIMIT = 16,
  parameter int W     = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_limit,
  output logic hit_limit
);

  logic [W-1:0] cnt;

  assign at_limit  = (cnt == W'(LIMIT));
  assign hit_limit = en && (cnt == W'(LIMIT - 1));

  // Count enabled cycles, hold at LIMIT, clear takes priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/extern_bus_arbiter.sv
// Shares the external peripheral register bus between the core and a host port.
// Core accesses always win; a latched host access takes the first free slot, and a
// one-cycle core stall is forced once the host has been blocked WAIT_LIMIT cycles.
module extern_bus_arbiter
  import extern_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int WAIT_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_bus_req,
  input  logic                  core_wr_en,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_starve,
  output logic [ADDR_WIDTH-1:0] per_addr,
  output logic [DATA_WIDTH-1:0] per_wdata,
  output logic                  per_wr_en,
  output logic                  per_rd_en,
  input  logic [DATA_WIDTH-1:0] per_rdata,
  output logic                  per_src_host
);

  arb_state_e state, state_nxt;

  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic host_slot;
  logic core_slot;
  logic blocked;
  logic at_limit;
  logic hit_limit;
  logic stall_nxt;

  // The core owns the bus whenever it asks, except in a forced stall cycle.
  assign core_slot  = core_bus_req && !core_stall;
  assign host_slot  = (state == PEND) && !core_slot;
  assign blocked    = (state == PEND) && core_slot;
  assign stall_nxt  = blocked && (hit_limit || at_limit);
  assign core_rdata = per_rdata;

  sat_counter #(
    .LIMIT (WAIT_LIMIT)
  ) u_wait_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state == DONE),
    .en        (blocked),
    .at_limit  (at_limit),
    .hit_limit (hit_limit)
  );

  // Next-state logic; the ack pulse is simply the single DONE cycle.
  always_comb begin
    state_nxt = state;
    host_ack  = 1'b0;
    unique case (state)
      IDLE: if (host_req) state_nxt = PEND;
      PEND: if (host_slot) state_nxt = DONE;
      DONE: begin
        host_ack  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, stall pulse, starvation flag and captured host read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      core_stall  <= 1'b0;
      host_starve <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      core_stall <= stall_nxt;
      if (stall_nxt) begin
        host_starve <= 1'b1;
      end else if (host_ack) begin
        host_starve <= 1'b0;
      end
      if (host_slot && !lat_we) begin
        host_rdata <= per_rdata;
      end
    end
  end

  // Request fields are captured once when a new host request is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && host_req) begin
      lat_we    <= host_we;
      lat_addr  <= host_addr;
      lat_wdata <= host_wdata;
    end
  end

  // Bus mux: host slot from the latch, else core, else an idle bus driven to zero.
  always_comb begin
    per_addr     = '0;
    per_wdata    = '0;
    per_wr_en    = 1'b0;
    per_rd_en    = 1'b0;
    per_src_host = 1'b0;
    if (host_slot) begin
      per_addr     = lat_addr;
      per_wdata    = lat_wdata;
      per_wr_en    = lat_we;
      per_rd_en    = !lat_we;
      per_src_host = 1'b1;
    end else if (core_slot) begin
      per_addr  = core_addr;
      per_wdata = core_wdata;
      per_wr_en = core_wr_en;
      per_rd_en = !core_wr_en;
    end
  end

endmodule

// File: tb/tb_extern_bus_arbiter.sv
// Bench for extern_bus_arbiter: peripheral register array, transaction-level
// reference model checked every cycle, plus directed scenarios with literal results.
module tb_extern_bus_arbiter;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int WL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_bus_req, core_wr_en;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          core_stall;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_ack, host_starve;
  logic [AW-1:0] per_addr;
  logic [DW-1:0] per_wdata, per_rdata;
  logic          per_wr_en, per_rd_en, per_src_host;

  extern_bus_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WAIT_LIMIT (WL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_bus_req (core_bus_req),
    .core_wr_en   (core_wr_en),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_rdata   (core_rdata),
    .core_stall   (core_stall),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ack     (host_ack),
    .host_rdata   (host_rdata),
    .host_starve  (host_starve),
    .per_addr     (per_addr),
    .per_wdata    (per_wdata),
    .per_wr_en    (per_wr_en),
    .per_rd_en    (per_rd_en),
    .per_rdata    (per_rdata),
    .per_src_host (per_src_host)
  );

  always #5 clk = ~clk;

  // Peripheral register file: initial contents are addr[7:0] ^ 0x5A.
  logic [DW-1:0] mem [0:511];
  bit            mem_ready = 1'b0;
  logic [DW-1:0] a5_log [$];

  assign per_rdata = mem[per_addr];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem_ready <= 1'b1;
    end else if (per_wr_en) begin
      mem[per_addr] <= per_wdata;
      if (per_addr == 9'h0A5) a5_log.push_back(per_wdata);
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Observed events
  int ack_n = 0, rd_n = 0, wr_n = 0, src_n = 0, stall_n = 0;
  int ack_q [$];
  int last_src = -1, last_stall = -1;
  logic [DW-1:0] last_ack_rdata;
  logic last_ack_starve, last_stall_starve;

  // Reference model state
  bit            m_pend = 0, m_stall = 0, m_ack = 0, m_starve = 0, m_we = 0;
  int            m_blk = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic          turn, cown, ew, er, es;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (!rst_n) begin
      m_pend = 0; m_blk = 0; m_stall = 0; m_ack = 0; m_starve = 0; m_rdata = '0;
    end
    turn = m_pend && (!core_bus_req || m_stall);
    cown = core_bus_req && !m_stall;
    ea = '0; ed = '0; ew = 0; er = 0; es = 0;
    if (turn) begin
      ea = m_addr; ed = m_wdata; ew = m_we; er = !m_we; es = 1;
    end else if (cown) begin
      ea = core_addr; ed = core_wdata; ew = core_wr_en; er = !core_wr_en;
    end
    chk("core_stall",   core_stall,   m_stall);
    chk("host_ack",     host_ack,     m_ack);
    chk("host_rdata",   host_rdata,   m_rdata);
    chk("host_starve",  host_starve,  m_starve);
    chk("per_addr",     per_addr,     ea);
    chk("per_wdata",    per_wdata,    ed);
    chk("per_wr_en",    per_wr_en,    ew);
    chk("per_rd_en",    per_rd_en,    er);
    chk("per_src_host", per_src_host, es);
    chk("core_rdata",   core_rdata,   mem[ea]);
    if (host_ack === 1'b1) begin
      ack_n++; ack_q.push_back(cyc);
      last_ack_rdata = host_rdata; last_ack_starve = host_starve;
    end
    if (per_rd_en === 1'b1) rd_n++;
    if (per_wr_en === 1'b1) wr_n++;
    if (per_src_host === 1'b1) begin src_n++; last_src = cyc; end
    if (core_stall === 1'b1) begin
      stall_n++; last_stall = cyc; last_stall_starve = host_starve;
    end
    if (rst_n) begin
      if (m_ack) begin
        m_ack = 0; m_starve = 0;
      end else if (turn) begin
        m_pend = 0; m_ack = 1; m_stall = 0;
        if (!m_we) m_rdata = mem[m_addr];
      end else if (m_pend) begin
        m_blk++;
        if (m_blk == WL) begin m_stall = 1; m_starve = 1; end
      end else if (host_req) begin
        m_pend = 1; m_blk = 0;
        m_we = host_we; m_addr = host_addr; m_wdata = host_wdata;
      end
    end
  endtask

  // Check the current cycle at the falling edge, then move to just after the next rise.
  task automatic cyc_step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_acks(input int base, input int need, input string nm);
    int k = 0;
    while ((ack_n - base) < need && k < 30) begin
      cyc_step();
      k++;
    end
    if ((ack_n - base) < need) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got %0d acks, expected %0d", nm, ack_n - base, need);
    end
  endtask

  task automatic host_drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic core_drive(input logic req, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    core_bus_req = req; core_wr_en = we; core_addr = a; core_wdata = d;
  endtask

  initial begin
    int c0, b_ack, b_rd, b_wr, b_src, b_stall, b_log;
    rst_n = 1'b0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    core_drive(0, 0, '0, '0);
    repeat (3) cyc_step();
    chk("reset_stall",  core_stall,  0);
    chk("reset_ack",    host_ack,    0);
    chk("reset_rdata",  host_rdata,  0);
    chk("reset_starve", host_starve, 0);
    rst_n = 1'b1;
    repeat (2) cyc_step();

    // Host read 0x105 with the core idle
    c0 = cyc; b_ack = ack_n; b_rd = rd_n;
    host_drive(0, 9'h105, 8'h00);
    wait_acks(b_ack, 1, "t1");
    host_req = 0;
    chk("t1_latency", ack_q[ack_q.size()-1] - c0, 2);
    chk("t1_rdata",   last_ack_rdata, 8'h5F);
    chk("t1_rd_pulses", rd_n - b_rd, 1);
    repeat (2) cyc_step();

    // Host write 0x0A5=0x3C while the core uses the bus for 3 cycles
    c0 = cyc; b_ack = ack_n; b_src = src_n;
    host_drive(1, 9'h0A5, 8'h3C);
    cyc_step(); core_drive(1, 0, 9'h010, 8'h00);
    cyc_step(); core_drive(1, 1, 9'h020, 8'h99);
    cyc_step(); core_drive(1, 0, 9'h012, 8'h00);
    cyc_step(); core_drive(0, 0, '0, '0);
    wait_acks(b_ack, 1, "t2");
    host_req = 0;
    chk("t2_issue_cycle", last_src - c0, 4);
    chk("t2_src_cycles",  src_n - b_src, 1);
    chk("t2_ack_cycle",   ack_q[ack_q.size()-1] - c0, 5);
    chk("t2_mem_a5",      mem[9'h0A5], 8'h3C);
    chk("t2_core_write",  mem[9'h020], 8'h99);
    repeat (2) cyc_step();

    // Core requesting continuously: the stall forces the host write through
    c0 = cyc; b_ack = ack_n; b_stall = stall_n;
    host_drive(1, 9'h0C0, 8'h77);
    cyc_step(); core_drive(1, 0, 9'h030, 8'h00);
    wait_acks(b_ack, 1, "t3");
    chk("t3_stall_pulses", stall_n - b_stall, 1);
    chk("t3_stall_cycle",  last_stall - c0, 5);
    chk("t3_issue_cycle",  last_src - c0, 5);
    chk("t3_ack_cycle",    ack_q[ack_q.size()-1] - c0, 6);
    chk("t3_starve_stall", last_stall_starve, 1);
    chk("t3_starve_ack",   last_ack_starve, 1);
    chk("t3_starve_clear", host_starve, 0);
    chk("t3_mem_c0",       mem[9'h0C0], 8'h77);
    host_req = 0; core_drive(0, 0, '0, '0);
    repeat (2) cyc_step();

    // Core and host write the same register in the same cycle
    b_ack = ack_n; b_log = a5_log.size();
    core_drive(1, 1, 9'h0A5, 8'h11);
    host_drive(1, 9'h0A5, 8'h22);
    cyc_step(); core_drive(0, 0, '0, '0);
    wait_acks(b_ack, 1, "t4");
    host_req = 0;
    chk("t4_write_count", a5_log.size() - b_log, 2);
    if (a5_log.size() >= b_log + 2) begin
      chk("t4_first_write",  a5_log[b_log],     8'h11);
      chk("t4_second_write", a5_log[b_log + 1], 8'h22);
    end
    chk("t4_final", mem[9'h0A5], 8'h22);
    repeat (2) cyc_step();

    // Reset while a host read is pending
    host_drive(0, 9'h033, 8'h00);
    core_drive(1, 0, 9'h040, 8'h00);
    repeat (2) cyc_step();
    rst_n = 0; host_req = 0; core_drive(0, 0, '0, '0);
    #1;
    chk("t5_rst_ack",    host_ack, 0);
    chk("t5_rst_stall",  core_stall, 0);
    chk("t5_rst_starve", host_starve, 0);
    chk("t5_rst_rdata",  host_rdata, 0);
    chk("t5_rst_rd",     per_rd_en, 0);
    chk("t5_rst_wr",     per_wr_en, 0);
    chk("t5_rst_addr",   per_addr, 0);
    chk("t5_rst_src",    per_src_host, 0);
    b_ack = ack_n; b_rd = rd_n; b_wr = wr_n;
    repeat (3) cyc_step();
    rst_n = 1;
    repeat (2) cyc_step();
    chk("t5_no_ack",    ack_n - b_ack, 0);
    chk("t5_no_strobe", (rd_n - b_rd) + (wr_n - b_wr), 0);
    c0 = cyc; b_ack = ack_n;
    host_drive(0, 9'h033, 8'h00);
    wait_acks(b_ack, 1, "t5");
    host_req = 0;
    chk("t5_latency", ack_q[ack_q.size()-1] - c0, 2);
    chk("t5_rdata",   last_ack_rdata, 8'h69);
    repeat (2) cyc_step();

    // host_req held high past the ack: two back-to-back transactions
    c0 = cyc; b_ack = ack_n;
    host_drive(0, 9'h010, 8'h00);
    wait_acks(b_ack, 2, "t6");
    host_req = 0;
    chk("t6_ack_count", ack_n - b_ack, 2);
    if (ack_q.size() >= b_ack + 2) begin
      chk("t6_first_ack",  ack_q[b_ack] - c0, 2);
      chk("t6_second_ack", ack_q[b_ack + 1] - c0, 5);
    end
    chk("t6_rdata", last_ack_rdata, 8'h4A);
    repeat (3) cyc_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
